spi_mem_burst: RTL and testbench

//  Parametrised bit-serial memory slave; successor to the fixed 8x32 SPI memory.

---
 rtl/spi_mem_pkg.sv | 17 +
 rtl/spi_mem_array.sv | 27 ++
 rtl/spi_mem_burst.sv | 196 +++++++++++++++++++
 tb/tb_spi_mem_burst.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// rtl/spi_mem_pkg.sv - shared state encoding and command codes for the burst SPI memory slave
package spi_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_LEN,
    ST_WDATA,
    ST_RLOAD,
    ST_RDATA
  } state_e;

  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;

endpackage

// File: rtl/spi_mem_array.sv
// rtl/spi_mem_array.sv - single-port storage, synchronous write and enable-gated registered read
module spi_mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read register only loads on demand so it can serve as the read shift word.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_mem_burst.sv
// rtl/spi_mem_burst.sv - bit-serial burst memory slave with auto-increment, wrap and frame abort
module spi_mem_burst
  import spi_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int LEN_W  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic miso,
  output logic mosi,
  output logic ready,
  output logic op_done,
  output logic err
);

  localparam int MAX_W = (DATA_W > ADDR_W) ? ((DATA_W > LEN_W) ? DATA_W : LEN_W)
                                           : ((ADDR_W > LEN_W) ? ADDR_W : LEN_W);
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  state_e              state_q, state_d;
  logic                armed_q, armed_d;
  logic                cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic [LEN_W-1:0]    word_q, word_d;
  logic [DATA_W-2:0]   shift_q, shift_d;
  logic                rd_last_q, rd_last_d;
  logic                mosi_q, mosi_d;
  logic                ready_q, ready_d;
  logic                op_done_q, op_done_d;
  logic                err_q, err_d;
  logic                mem_we, mem_re;
  logic [DATA_W-1:0]   mem_wdata, mem_rdata;

  spi_mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .we_i    (mem_we & ~rst),
    .re_i    (mem_re & ~rst),
    .addr_i  (addr_q),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    len_d     = len_q;
    bit_d     = bit_q;
    word_d    = word_q;
    shift_d   = shift_q;
    rd_last_d = rd_last_q;
    mosi_d    = 1'b0;
    ready_d   = 1'b0;
    op_done_d = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = {miso, shift_q};

    if (state_q != ST_IDLE && cs) begin
      state_d   = ST_IDLE;
      err_d     = 1'b1;
      bit_d     = '0;
      word_d    = '0;
      rd_last_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          bit_d  = '0;
          word_d = '0;
          if (cs) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            armed_d = 1'b0;
            state_d = ST_CMD;
          end
        end
        ST_CMD: begin
          cmd_d   = miso;
          state_d = ST_ADDR;
        end
        ST_ADDR: begin
          addr_d = {miso, addr_q[ADDR_W-1:1]};
          if (bit_q == CNT_W'(ADDR_W - 1)) begin
            bit_d   = '0;
            state_d = ST_LEN;
          end else begin
            bit_d = bit_q + CNT_W'(1);
          end
        end
        ST_LEN: begin
          len_d = {miso, len_q[LEN_W-1:1]};
          if (bit_q == CNT_W'(LEN_W - 1)) begin
            bit_d   = '0;
            word_d  = '0;
            state_d = (cmd_q == CMD_WR) ? ST_WDATA : ST_RLOAD;
          end else begin
            bit_d = bit_q + CNT_W'(1);
          end
        end
        ST_WDATA: begin
          shift_d = {miso, shift_q[DATA_W-2:1]};
          if (bit_q == CNT_W'(DATA_W - 1)) begin
            mem_we = 1'b1;
            addr_d = addr_q + ADDR_W'(1);
            bit_d  = '0;
            if (word_q == len_q) begin
              op_done_d = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              word_d = word_q + LEN_W'(1);
            end
          end else begin
            bit_d = bit_q + CNT_W'(1);
          end
        end
        ST_RLOAD: begin
          mem_re    = 1'b1;
          addr_d    = addr_q + ADDR_W'(1);
          bit_d     = '0;
          word_d    = '0;
          rd_last_d = 1'b0;
          state_d   = ST_RDATA;
        end
        ST_RDATA: begin
          // rd_last_q marks the trailing idle cycle that carries op_done.
          if (rd_last_q) begin
            op_done_d = 1'b1;
            rd_last_d = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            ready_d = 1'b1;
            mosi_d  = |(mem_rdata & (DATA_W'(1) << bit_q));
            if (bit_q == CNT_W'(DATA_W - 1)) begin
              bit_d = '0;
              if (word_q == len_q) begin
                rd_last_d = 1'b1;
              end else begin
                word_d = word_q + LEN_W'(1);
                mem_re = 1'b1;
                addr_d = addr_q + ADDR_W'(1);
              end
            end else begin
              bit_d = bit_q + CNT_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      armed_q   <= 1'b1;
      cmd_q     <= CMD_RD;
      addr_q    <= '0;
      len_q     <= '0;
      bit_q     <= '0;
      word_q    <= '0;
      shift_q   <= '0;
      rd_last_q <= 1'b0;
      mosi_q    <= 1'b0;
      ready_q   <= 1'b0;
      op_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      bit_q     <= bit_d;
      word_q    <= word_d;
      shift_q   <= shift_d;
      rd_last_q <= rd_last_d;
      mosi_q    <= mosi_d;
      ready_q   <= ready_d;
      op_done_q <= op_done_d;
      err_q     <= err_d;
    end
  end

  assign mosi    = mosi_q;
  assign ready   = ready_q;
  assign op_done = op_done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_spi_mem_burst.sv
// tb/tb_spi_mem_burst.sv - scoreboard bench for spi_mem_burst at default and wide parameters
module tb_spi_mem_burst;

  logic clk = 1'b0;
  logic rst;
  logic cs_a, miso_a, mosi_a, ready_a, op_done_a, err_a;
  logic cs_b, miso_b, mosi_b, ready_b, op_done_b, err_b;

  always #5 clk = ~clk;

  spi_mem_burst dut_a (
    .clk(clk), .rst(rst), .cs(cs_a), .miso(miso_a),
    .mosi(mosi_a), .ready(ready_a), .op_done(op_done_a), .err(err_a)
  );

  spi_mem_burst #(.DATA_W(16), .ADDR_W(8), .LEN_W(2)) dut_b (
    .clk(clk), .rst(rst), .cs(cs_b), .miso(miso_b),
    .mosi(mosi_b), .ready(ready_b), .op_done(op_done_b), .err(err_b)
  );

  int n_chk = 0;
  int n_err = 0;
  int op_cnt = 0;
  int err_cnt = 0;
  int run = 0;
  int exp_run = 0;
  bit run_chk = 1'b1;
  bit cur = 1'b0;
  logic exp_q[$];
  logic [15:0] wq[$];
  logic [15:0] model [2][256];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic c_ready();
    return cur ? ready_b : ready_a;
  endfunction

  function automatic logic c_mosi();
    return cur ? mosi_b : mosi_a;
  endfunction

  always @(negedge clk) begin
    logic r, m, o, e;
    r = c_ready();
    m = c_mosi();
    o = cur ? op_done_b : op_done_a;
    e = cur ? err_b : err_a;
    if (o) op_cnt++;
    if (e) err_cnt++;
    if (o | e) chk("done_err_excl", {31'd0, o & e}, 0);
    if (r) begin
      run++;
      if (exp_q.size() == 0) chk("rd_extra", 1, 0);
      else chk("rd_bit", {31'd0, m}, {31'd0, exp_q.pop_front()});
    end else begin
      if (m) chk("mosi_idle", 1, 0);
      if (run != 0) begin
        if (run_chk) chk("ready_run", run, exp_run);
        run = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drv(input bit s, input logic c, input logic m);
    if (s) begin cs_b = c; miso_b = m; end
    else begin cs_a = c; miso_a = m; end
  endtask

  task automatic send(input bit s, input logic b);
    drv(s, 1'b0, b);
    tick();
  endtask

  task automatic header(input bit s, input logic cmd, input int addr, input int len);
    int aw, lw;
    aw = s ? 8 : 5;
    lw = s ? 2 : 4;
    cur = s;
    drv(s, 1'b0, 1'b0);
    tick();
    send(s, cmd);
    for (int i = 0; i < aw; i++) send(s, 1'((addr >> i) & 1));
    for (int i = 0; i < lw; i++) send(s, 1'((len >> i) & 1));
  endtask

  task automatic wr_frame(input bit s, input int addr, input int len, input int abort_bits, input bit hold);
    int dw, dep, ops, errs, n;
    bit aborted;
    dw = s ? 16 : 8;
    dep = s ? 256 : 32;
    ops = op_cnt;
    errs = err_cnt;
    n = 0;
    aborted = 1'b0;
    header(s, 1'b1, addr, len);
    for (int w = 0; w <= len && !aborted; w++) begin
      for (int b = 0; b < dw && !aborted; b++) begin
        if (n == abort_bits) aborted = 1'b1;
        else begin
          send(s, wq[w][b]);
          n++;
        end
      end
      if (!aborted) model[s][(addr + w) % dep] = wq[w];
    end
    if (aborted) begin
      drv(s, 1'b1, 1'b0);
      tick();
      tick();
      chk("abort_err", err_cnt - errs, 1);
      chk("abort_no_done", op_cnt - ops, 0);
    end else begin
      tick();
      chk("wr_done", op_cnt - ops, 1);
      chk("wr_no_err", err_cnt - errs, 0);
      if (!hold) begin
        drv(s, 1'b1, 1'b0);
        tick();
      end
    end
  endtask

  task automatic rd_frame(input bit s, input int addr, input int len, input int rst_at);
    int dw, dep, ops, errs, total, k;
    dw = s ? 16 : 8;
    dep = s ? 256 : 32;
    ops = op_cnt;
    errs = err_cnt;
    total = (len + 1) * dw;
    header(s, 1'b0, addr, len);
    for (int w = 0; w <= len; w++)
      for (int b = 0; b < dw; b++) exp_q.push_back(model[s][(addr + w) % dep][b]);
    exp_run = total;
    tick();
    chk("lat_pre", {31'd0, c_ready()}, 0);
    tick();
    chk("lat_first", {31'd0, c_ready()}, 1);
    if (rst_at >= 0) begin
      run_chk = 1'b0;
      repeat (rst_at) tick();
      rst = 1'b1;
      drv(s, 1'b1, 1'b0);
      tick();
      chk("rst_ready", {31'd0, c_ready()}, 0);
      chk("rst_mosi", {31'd0, c_mosi()}, 0);
      chk("rst_no_err", err_cnt - errs, 0);
      rst = 1'b0;
      exp_q.delete();
      tick();
      run_chk = 1'b1;
    end else begin
      k = 0;
      while (op_cnt == ops && k < total + 10) begin
        tick();
        k++;
      end
      chk("rd_done", op_cnt - ops, 1);
      chk("rd_no_err", err_cnt - errs, 0);
      chk("rd_left", exp_q.size(), 0);
      drv(s, 1'b1, 1'b0);
      tick();
    end
  endtask

  initial begin
    int ops0, errs0;
    rst = 1'b1;
    cs_a = 1'b1; miso_a = 1'b0;
    cs_b = 1'b1; miso_b = 1'b0;
    repeat (3) tick();
    chk("rst_mosi_a", {31'd0, mosi_a}, 0);
    chk("rst_ready_a", {31'd0, ready_a}, 0);
    chk("rst_op_done_a", {31'd0, op_done_a}, 0);
    chk("rst_err_a", {31'd0, err_a}, 0);
    chk("rst_ready_b", {31'd0, ready_b}, 0);
    chk("rst_err_b", {31'd0, err_b}, 0);
    rst = 1'b0;
    repeat (2) tick();

    wq = {16'h00A5};
    wr_frame(0, 'h03, 0, -1, 0);
    rd_frame(0, 'h03, 0, -1);

    wq = {16'h0011, 16'h0022, 16'h0033, 16'h0044};
    wr_frame(0, 'h1E, 3, -1, 0);
    rd_frame(0, 'h1E, 3, -1);
    rd_frame(0, 'h00, 1, -1);

    wq = {16'h003C};
    wr_frame(0, 'h05, 0, -1, 0);
    wq = {16'h00C3};
    wr_frame(0, 'h05, 0, 4, 0);
    rd_frame(0, 'h05, 0, -1);
    wq = {16'h005A};
    wr_frame(0, 'h05, 0, -1, 0);
    rd_frame(0, 'h05, 0, -1);

    wq = {16'h0096};
    wr_frame(0, 'h08, 0, -1, 1);
    ops0 = op_cnt;
    errs0 = err_cnt;
    for (int i = 0; i < 20; i++) begin
      drv(0, 1'b0, 1'($urandom_range(0, 1)));
      tick();
    end
    chk("hold_no_done", op_cnt - ops0, 0);
    chk("hold_no_err", err_cnt - errs0, 0);
    drv(0, 1'b1, 1'b0);
    repeat (2) tick();
    rd_frame(0, 'h08, 0, -1);

    wq = {16'h00DE, 16'h00AD, 16'h0001};
    wr_frame(0, 'h10, 2, -1, 0);
    rd_frame(0, 'h10, 2, 9);
    rd_frame(0, 'h10, 2, -1);
    rd_frame(0, 'h03, 0, -1);

    wq = {16'hBEEF, 16'h1234};
    wr_frame(1, 'hFF, 1, -1, 0);
    rd_frame(1, 'hFF, 1, -1);
    rd_frame(1, 'h00, 0, -1);
    cur = 1'b0;

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
